// File: rtl/fm_phase_accumulator.sv
// fm_phase_accumulator
//   Upstream phase generator for the rotation-mode CORDIC in the FM transmitter.
//   Each strobed audio sample advances the phase by
//     center_freq + (audio * dev_gain) >>> KSHIFT      (all modulo 2^PWIDTH)
//   and the top ZWIDTH bits of the accumulator are presented as zo. Full scale
//   of zo is one turn, matching the CORDIC quadrant convention on zi.
//   Three register stages: product/carrier capture, increment sum, accumulate.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   audio          signed sample, valid with stb_in
//   stb_in         one-cycle sample strobe (full rate supported, no backpressure)
//   center_freq    carrier word (turns/sample * 2^PWIDTH), sampled with stb_in
//   dev_gain       unsigned deviation gain, sampled with stb_in
//   phase_clr      synchronous accumulator clear (wins over an arriving increment)
//   xo, yo         constant AMPL / 0 for the CORDIC x/y inputs
//   zo, stb_out    phase word and its valid strobe (3 cycles after stb_in)
//
// Build option
//   PHASE_DITHER_EN : adds a 16-bit LFSR dither below the zo truncation point.
module fm_phase_accumulator #(
  parameter int AWIDTH = 16,
  parameter int KWIDTH = 16,
  parameter int KSHIFT = 0,
  parameter int PWIDTH = 32,
  parameter int ZWIDTH = 24,
  parameter int WIDTH  = 16,
  parameter int AMPL   = 19896
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] audio,
  input  logic              stb_in,
  input  logic [PWIDTH-1:0] center_freq,
  input  logic [KWIDTH-1:0] dev_gain,
  input  logic              phase_clr,
  output logic [WIDTH-1:0]  xo,
  output logic [WIDTH-1:0]  yo,
  output logic [ZWIDTH-1:0] zo,
  output logic              stb_out
);

  localparam int PRW = AWIDTH + KWIDTH + 1;

  logic signed [PRW-1:0] audio_ext, gain_ext, prod_r, prod_sh;
  logic [PWIDTH-1:0]     cf_r, inc_r, phase, next_phase, prod_ext;
  logic [ZWIDTH-1:0]     zo_r, zo_next;
  logic                  v1, v2, v3;

  // Gain is unsigned: zero-extend so the product is a signed*positive multiply.
  assign audio_ext = {{(KWIDTH+1){audio[AWIDTH-1]}}, audio};
  assign gain_ext  = {{AWIDTH{1'b0}}, dev_gain};

  // Size cast of a signed value sign-extends or truncates (modulo) to PWIDTH.
  assign prod_sh  = prod_r >>> KSHIFT;
  assign prod_ext = PWIDTH'(prod_sh);

  assign next_phase = phase + inc_r;

`ifdef PHASE_DITHER_EN
  localparam int DW = (PWIDTH - ZWIDTH < 16) ? (PWIDTH - ZWIDTH) : 16;

  logic [15:0]       lfsr;
  logic [PWIDTH-1:0] dith, dith_phase;
  logic              lfsr_fb;

  // Fibonacci taps 16,14,13,11.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  generate
    if (DW > 0) begin : g_dith
      assign dith = {{(PWIDTH-DW){1'b0}}, lfsr[DW-1:0]};
    end else begin : g_nodith
      assign dith = '0;
    end
  endgenerate

  // Dither only affects the truncated output; the accumulator stays exact.
  assign dith_phase = next_phase + dith;
  assign zo_next    = ZWIDTH'(dith_phase >> (PWIDTH - ZWIDTH));

  always_ff @(posedge clk) begin
    if (rst)     lfsr <= 16'hACE1;
    else if (v2) lfsr <= {lfsr[14:0], lfsr_fb};
  end
`else
  assign zo_next = ZWIDTH'(next_phase >> (PWIDTH - ZWIDTH));
`endif

  // Stage 1: capture product and carrier word.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      prod_r <= '0;
      cf_r   <= '0;
    end else begin
      v1 <= stb_in;
      if (stb_in) begin
        prod_r <= audio_ext * gain_ext;
        cf_r   <= center_freq;
      end
    end
  end

  // Stage 2: per-sample phase increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      inc_r <= '0;
    end else begin
      v2 <= v1;
      if (v1) inc_r <= cf_r + prod_ext;
    end
  end

  // Stage 3: accumulate. A clear discards the increment but still lets its
  // strobe through, so downstream sees a valid zo of 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3    <= 1'b0;
      phase <= '0;
      zo_r  <= '0;
    end else begin
      v3 <= v2;
      if (phase_clr) begin
        phase <= '0;
        zo_r  <= '0;
      end else if (v2) begin
        phase <= next_phase;
        zo_r  <= zo_next;
      end
    end
  end

  assign xo      = WIDTH'(AMPL);
  assign yo      = '0;
  assign zo      = zo_r;
  assign stb_out = v3;

endmodule
